spi_byte_sequencer: RTL and testbench
=====================================

# spi_byte_sequencer

Byte-stream front end that sits directly upstream of the SPI driver. It buffers outgoing bytes in a TX FIFO, launches one driver transfer per byte with a single-cycle start pulse, waits for the driver's busy/enable window to open and close, and pushes the captured receive byte into an RX FIFO. It frames multi-byte transactions with a chip-select, and flags a driver that never responds.

## Interface
Parameters:
- DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, ≥2.
- TIMEOUT, 64: cycles allowed between the start pulse and the driver's busy going high; ≥4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low (one clock; polarity and synchronicity fixed).
- tx_data  in  8  byte to transmit.
- tx_last  in  1  byte ends the current frame; cs_n deasserts after it.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  received byte.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data.
- spi_data_in  out  8  byte presented to the driver's parallel input.
- spi_start  out  1  driver start pulse.
- spi_en  in  1  driver busy/enable.
- spi_data_out  in  8  driver's received byte.
- cs_n  out  1  frame chip-select, active-low.
- err_timeout  out  1  sticky error; cleared only by reset.

## Operation
- TX FIFO entry is 9 bits {tx_last, tx_data}. A write occurs when tx_valid && tx_ready. The RX FIFO is 8 bits. A pop occurs when rx_valid && rx_ready.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE, GAP.
- IDLE: if the TX FIFO is non-empty, the RX FIFO is not full, and err_timeout=0, pop the TX head into a holding register (byte, last flag). Set cs_n=0, then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: spi_start=1 for exactly this one cycle; spi_data_in = held byte. Load the timeout counter with TIMEOUT-1. Go to WAIT_BUSY.
- WAIT_BUSY: spi_start=0.
  - spi_en=1: go to WAIT_DONE.
  - Counter reaches 0: set err_timeout, set cs_n=1, go to IDLE. The held byte is dropped and nothing is pushed to RX.
- WAIT_DONE: stay while spi_en=1. On spi_en=0, go to CAPTURE.
- CAPTURE: push spi_data_out into the RX FIFO; space is guaranteed by the IDLE check. If the held last flag is 1, set cs_n=1. Go to GAP.
- GAP: one idle cycle so that spi_start has a low cycle between pulses. Go to IDLE.
- spi_data_in holds its value from LAUNCH until the next LAUNCH.
- Once err_timeout=1, no further launches occur. TX writes are still accepted until the FIFO is full.
- FIFO occupancy uses a count width of $clog2(DEPTH)+1. Pointers wrap modulo DEPTH. A simultaneous push and pop on a full or empty FIFO follows the normal rules: a push when full is not allowed (ready=0); a pop when empty is not allowed (valid=0); a push and pop in the same cycle leaves the count unchanged.

## Timing
- Reset values: spi_start=0, spi_data_in=8'h00, cs_n=1, err_timeout=0, both FIFOs empty, and therefore tx_ready=1 and rx_valid=0. FSM=IDLE.
- Assertion of rst_n mid-transfer aborts immediately on the next clk edge. No RX push occurs and cs_n=1.
- tx_ready and rx_valid are combinational from the registered FIFO counts. All other outputs are registered.
- Latency for a byte written at edge N into an empty TX FIFO with the FSM in IDLE:
  - cs_n=0 and state LAUNCH from N+1.
  - spi_start=1 during cycle N+1..N+2.
  - rx_valid rises the cycle after the CAPTURE edge.
- Minimum spacing between start pulses is 5 cycles (LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE, GAP) plus the driver's busy time.
- Within a frame, cs_n stays low across the GAP and IDLE states if the next byte is already queued. If the next byte is not queued, cs_n stays low and waits.

## Structure
- Package spi_seq_pkg holds:
  - the state enum typedef (seq_state_t);
  - the TX entry struct typedef {last, data};
  - the default TIMEOUT and DEPTH localparams.
- One sub-module, spi_seq_fifo, parameterised on WIDTH and DEPTH, is instantiated twice (TX WIDTH=9, RX WIDTH=8). The FSM and timeout counter live in the top module.

## Test plan
- Single byte 8'hA5 with tx_last=1; driver model raises spi_en 2 cycles after the start pulse, holds it 16 cycles, and returns 8'h3C → exactly one spi_start pulse, spi_data_in=8'hA5, rx_data=8'h3C, cs_n low→high after CAPTURE.
- Burst of 4 bytes 8'h01..8'h04, last flag on the 4th → 4 start pulses each ≥5 cycles apart, cs_n continuously low until after the 4th CAPTURE, RX order 01..04 echoed.
- rx_ready=0 with DEPTH=4 and 6 bytes queued → exactly 4 transfers, then the FSM holds in IDLE. Popping one RX entry releases exactly one more launch.
- Driver model never raises spi_en, TIMEOUT=64 → err_timeout=1 exactly 64 cycles after LAUNCH, cs_n=1, no RX push, and no further spi_start even with TX non-empty.
- Reset asserted during WAIT_DONE → next cycle all outputs at reset values, both FIFOs empty, and no stale rx_valid after release.
- TX FIFO full → tx_ready=0. A write and a launch-pop in the same cycle keep the count at DEPTH-1+1 with no data loss.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI byte sequencer: FSM state encoding,
// the TX FIFO entry layout and default sizing.
package spi_seq_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    GAP
  } seq_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with occupancy count; ready/valid flags are decoded
// combinationally from the registered count.
module spi_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             not_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign not_full  = (count != CW'(DEPTH));
  assign not_empty = (count != '0);
  assign do_push   = push && not_full;
  assign do_pop    = pop && not_empty;
  assign rdata     = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define
  // which entries are meaningful, so resetting the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for an SPI driver: TX/RX buffering, one start pulse
// per byte, chip-select framing and a sticky no-response timeout.
module spi_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] spi_data_in,
  output logic       spi_start,
  input  logic       spi_en,
  input  logic [7:0] spi_data_out,
  output logic       cs_n,
  output logic       err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  seq_state_t    state;
  tx_entry_t     tx_wentry;
  tx_entry_t     tx_head;
  logic          tx_not_empty;
  logic          rx_not_full;
  logic          launch_go;
  logic          rx_push;
  logic          held_last;
  logic [TW-1:0] timer;

  assign tx_wentry = '{last: tx_last, data: tx_data};
  assign launch_go = (state == IDLE) && tx_not_empty && rx_not_full && !err_timeout;
  assign rx_push   = (state == CAPTURE);

  spi_seq_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .wdata     (tx_wentry),
    .pop       (launch_go),
    .rdata     (tx_head),
    .not_full  (tx_ready),
    .not_empty (tx_not_empty)
  );

  spi_seq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .wdata     (spi_data_out),
    .pop       (rx_ready),
    .rdata     (rx_data),
    .not_full  (rx_not_full),
    .not_empty (rx_valid)
  );

  // spi_start is registered on the IDLE->LAUNCH edge so it is high for
  // exactly the LAUNCH cycle; the RX space check in IDLE makes CAPTURE safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      spi_start   <= 1'b0;
      spi_data_in <= 8'h00;
      cs_n        <= 1'b1;
      err_timeout <= 1'b0;
      held_last   <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch_go) begin
            held_last   <= tx_head.last;
            spi_data_in <= tx_head.data;
            spi_start   <= 1'b1;
            cs_n        <= 1'b0;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          spi_start <= 1'b0;
          timer     <= TW'(TIMEOUT - 1);
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Firing on the edge where the counter steps to zero makes the
          // error land exactly TIMEOUT cycles after the start pulse rose.
          if (spi_en) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(1)) begin
            timer       <= '0;
            err_timeout <= 1'b1;
            cs_n        <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!spi_en) state <= CAPTURE;
        end
        CAPTURE: begin
          if (held_last) cs_n <= 1'b1;
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Randomized bench for spi_byte_sequencer: a driver model answers start
// pulses and a queue-based reference predicts launch order and RX contents.
module tb_spi_byte_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic [7:0] tx_data      = 8'h00;
  logic       tx_last      = 1'b0;
  logic       tx_valid     = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready     = 1'b0;
  logic [7:0] spi_data_in;
  logic       spi_start;
  logic       spi_en       = 1'b0;
  logic [7:0] spi_data_out = 8'h00;
  logic       cs_n;
  logic       err_timeout;

  spi_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .spi_data_in  (spi_data_in),
    .spi_start    (spi_start),
    .spi_en       (spi_en),
    .spi_data_out (spi_data_out),
    .cs_n         (cs_n),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] txq[$];
  logic [7:0] rxq[$];
  int         n_starts = 0;
  int         n_cs_rise = 0;
  int         n_last_written = 0;
  int         last_start_cyc = 0;
  bit         have_prev_start = 1'b0;
  bit         prev_start = 1'b0;
  bit         prev_cs = 1'b1;
  bit         drv_silent = 1'b0;
  bit         rx_rand = 1'b0;
  int         drv_delay = 2;
  int         drv_busy_min = 1;
  int         drv_busy_max = 4;
  logic [7:0] resp_mask = 8'h00;

  // Reference: bytes launch in write order; each completed transfer yields
  // byte ^ resp_mask in the RX stream.
  always @(negedge clk) begin : monitor
    logic [8:0] exp_tx;
    logic [7:0] exp_rx;
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_cs    = 1'b1;
    end else begin
      if (tx_valid && tx_ready) begin
        txq.push_back({tx_last, tx_data});
        if (tx_last) n_last_written++;
      end
      if (prev_start) begin
        checks++;
        if (spi_start !== 1'b0) begin
          errors++;
          $display("FAIL start_width: spi_start=%b required 0 at cycle %0d", spi_start, cyc);
        end
      end
      if (spi_start && !prev_start) begin
        n_starts++;
        checks++;
        if (cs_n !== 1'b0) begin
          errors++;
          $display("FAIL cs_at_start: cs_n=%b required 0 at cycle %0d", cs_n, cyc);
        end
        if (have_prev_start) begin
          checks++;
          if (cyc - last_start_cyc < 5 + drv_busy_min) begin
            errors++;
            $display("FAIL start_spacing: gap=%0d required >=%0d", cyc - last_start_cyc, 5 + drv_busy_min);
          end
        end
        have_prev_start = 1'b1;
        last_start_cyc  = cyc;
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: launch with spi_data_in=%h but no byte pending", spi_data_in);
        end else begin
          exp_tx = txq.pop_front();
          if (spi_data_in !== exp_tx[7:0]) begin
            errors++;
            $display("FAIL launch_data: spi_data_in=%h required %h", spi_data_in, exp_tx[7:0]);
          end
          if (!drv_silent) rxq.push_back(exp_tx[7:0] ^ resp_mask);
        end
      end
      if (cs_n && !prev_cs) n_cs_rise++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (rxq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx: rx_data=%h popped with nothing expected", rx_data);
        end else begin
          exp_rx = rxq.pop_front();
          if (rx_data !== exp_rx) begin
            errors++;
            $display("FAIL rx_data: rx_data=%h required %h", rx_data, exp_rx);
          end
        end
      end
      prev_start = spi_start;
      prev_cs    = cs_n;
    end
  end

  // Driver model: busy window opens drv_delay cycles after the start pulse.
  always begin : driver
    logic [7:0] b;
    int         busy;
    @(negedge clk);
    if (rst_n && spi_start && !drv_silent) begin
      b    = spi_data_in ^ resp_mask;
      busy = $urandom_range(drv_busy_max, drv_busy_min);
      repeat (drv_delay) @(posedge clk);
      #1;
      spi_en       = 1'b1;
      spi_data_out = b;
      repeat (busy) @(posedge clk);
      #1;
      spi_en = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rx_rand) begin
      #1;
      rx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int t = 0;
    rx_rand = 1'b0;
    while (spi_en && t < 200) begin tick(); t++; end
    rst_n      = 1'b0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    drv_silent = 1'b0;
    tick(2);
    txq.delete();
    rxq.delete();
    n_starts        = 0;
    n_cs_rise       = 0;
    n_last_written  = 0;
    have_prev_start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic l);
    int t = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && t < 500) begin tick(); t++; end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: tx_ready stayed 0 for byte %h", d);
    end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((txq.size() != 0 || rxq.size() != 0 || rx_valid || spi_en) && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d launches and %0d RX bytes still pending", name, txq.size(), rxq.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (spi_start !== 1'b0)     begin errors++; $display("FAIL reset_start: got %b required 0", spi_start); end
    if (spi_data_in !== 8'h00)  begin errors++; $display("FAIL reset_data_in: got %h required 00", spi_data_in); end
    if (cs_n !== 1'b1)          begin errors++; $display("FAIL reset_cs_n: got %b required 1", cs_n); end
    if (err_timeout !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b required 0", err_timeout); end
    if (tx_ready !== 1'b1)      begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    if (rx_valid !== 1'b0)      begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
  endtask

  task automatic test_single();
    int t = 0;
    do_reset();
    resp_mask    = 8'h99;
    drv_delay    = 2;
    drv_busy_min = 16;
    drv_busy_max = 16;
    write_byte(8'hA5, 1'b1);
    tick();
    checks += 3;
    if (spi_start !== 1'b1)    begin errors++; $display("FAIL single_start: got %b required 1", spi_start); end
    if (cs_n !== 1'b0)         begin errors++; $display("FAIL single_cs_low: got %b required 0", cs_n); end
    if (spi_data_in !== 8'hA5) begin errors++; $display("FAIL single_data_in: got %h required a5", spi_data_in); end
    while (!rx_valid && t < 200) begin tick(); t++; end
    checks += 3;
    if (cyc != last_start_cyc + 20) begin errors++; $display("FAIL single_rx_latency: got %0d required %0d", cyc - last_start_cyc, 20); end
    if (rx_data !== 8'h3C)     begin errors++; $display("FAIL single_rx_data: got %h required 3c", rx_data); end
    if (cs_n !== 1'b1)         begin errors++; $display("FAIL single_cs_high: got %b required 1", cs_n); end
    rx_ready = 1'b1;
    wait_drain("single", 200);
    checks += 2;
    if (n_starts != 1)  begin errors++; $display("FAIL single_starts: got %0d required 1", n_starts); end
    if (n_cs_rise != 1) begin errors++; $display("FAIL single_cs_rise: got %0d required 1", n_cs_rise); end
  endtask

  task automatic test_burst();
    do_reset();
    resp_mask    = 8'h00;
    drv_busy_min = 1;
    drv_busy_max = 8;
    rx_ready     = 1'b1;
    for (int i = 1; i <= 4; i++) write_byte(8'(i), i == 4);
    wait_drain("burst", 400);
    checks += 2;
    if (n_starts != 4)  begin errors++; $display("FAIL burst_starts: got %0d required 4", n_starts); end
    if (n_cs_rise != 1) begin errors++; $display("FAIL burst_cs_rise: got %0d required 1", n_cs_rise); end
  endtask

  task automatic test_random();
    do_reset();
    resp_mask    = 8'($urandom);
    drv_delay    = 1 + $urandom_range(0, 2);
    drv_busy_min = 1;
    drv_busy_max = 6;
    rx_rand      = 1'b1;
    for (int i = 0; i < 24; i++) write_byte(8'($urandom), (i == 23) || ($urandom_range(0, 3) == 0));
    rx_rand = 1'b0;
    tick();
    rx_ready = 1'b1;
    wait_drain("random", 2000);
    checks++;
    if (n_cs_rise != n_last_written) begin
      errors++;
      $display("FAIL random_frames: cs_n rises=%0d required %0d", n_cs_rise, n_last_written);
    end
    drv_delay = 2;
  endtask

  task automatic test_backpressure();
    do_reset();
    resp_mask    = 8'h5A;
    drv_busy_min = 1;
    drv_busy_max = 8;
    for (int i = 0; i < 6; i++) write_byte(8'($urandom), i == 5);
    tick(150);
    checks += 3;
    if (n_starts != 4)     begin errors++; $display("FAIL bp_starts_full: got %0d required 4", n_starts); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL bp_rx_valid: got %b required 1", rx_valid); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL bp_tx_ready: got %b required 1", tx_ready); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick(100);
    checks++;
    if (n_starts != 5) begin errors++; $display("FAIL bp_one_release: got %0d required 5", n_starts); end
    rx_ready = 1'b1;
    wait_drain("bp", 400);
    checks++;
    if (n_starts != 6) begin errors++; $display("FAIL bp_starts_total: got %0d required 6", n_starts); end
  endtask

  task automatic test_tx_full();
    do_reset();
    resp_mask    = 8'hC3;
    drv_busy_min = 1;
    drv_busy_max = 4;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom), 1'b1);
    tick(100);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom), 1'b1);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL txfull_three: tx_ready=%b required 1", tx_ready); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tx_data  = 8'h77;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL txfull_simul: tx_ready=%b required 1", tx_ready); end
    write_byte(8'h88, 1'b1);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL txfull_full: tx_ready=%b required 0", tx_ready); end
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    checks++;
    if (n_starts != 5) begin errors++; $display("FAIL txfull_starts: got %0d required 5", n_starts); end
    rx_ready = 1'b1;
    wait_drain("txfull", 400);
    checks++;
    if (n_starts != 9) begin errors++; $display("FAIL txfull_starts_total: got %0d required 9", n_starts); end
  endtask

  task automatic test_reset_midtransfer();
    int t = 0;
    do_reset();
    resp_mask    = 8'h00;
    drv_busy_min = 40;
    drv_busy_max = 40;
    for (int i = 0; i < 3; i++) write_byte(8'h10 + 8'(i), i == 2);
    while (!spi_en && t < 100) begin tick(); t++; end
    tick(3);
    rst_n = 1'b0;
    tick();
    checks += 7;
    if (t >= 100)               begin errors++; $display("FAIL mid_no_busy: spi_en never rose"); end
    if (spi_start !== 1'b0)     begin errors++; $display("FAIL mid_start: got %b required 0", spi_start); end
    if (spi_data_in !== 8'h00)  begin errors++; $display("FAIL mid_data_in: got %h required 00", spi_data_in); end
    if (cs_n !== 1'b1)          begin errors++; $display("FAIL mid_cs_n: got %b required 1", cs_n); end
    if (err_timeout !== 1'b0)   begin errors++; $display("FAIL mid_err: got %b required 0", err_timeout); end
    if (tx_ready !== 1'b1)      begin errors++; $display("FAIL mid_tx_ready: got %b required 1", tx_ready); end
    if (rx_valid !== 1'b0)      begin errors++; $display("FAIL mid_rx_valid: got %b required 0", rx_valid); end
    txq.delete();
    rxq.delete();
    n_starts        = 0;
    have_prev_start = 1'b0;
    rst_n = 1'b1;
    t = 0;
    while (spi_en && t < 100) begin tick(); t++; end
    tick(30);
    checks += 2;
    if (n_starts != 0)     begin errors++; $display("FAIL mid_stale_launch: got %0d starts required 0", n_starts); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rx: rx_valid=%b required 0", rx_valid); end
    drv_busy_min = 1;
    drv_busy_max = 4;
  endtask

  task automatic test_timeout();
    int t = 0;
    do_reset();
    drv_silent = 1'b1;
    write_byte(8'h21, 1'b0);
    write_byte(8'h22, 1'b1);
    while (!err_timeout && t < 300) begin tick(); t++; end
    checks += 4;
    if (t >= 300)                         begin errors++; $display("FAIL to_never: err_timeout never rose"); end
    if (cyc - last_start_cyc != TIMEOUT)  begin errors++; $display("FAIL to_latency: got %0d required %0d", cyc - last_start_cyc, TIMEOUT); end
    if (cs_n !== 1'b1)                    begin errors++; $display("FAIL to_cs_n: got %b required 1", cs_n); end
    if (rx_valid !== 1'b0)                begin errors++; $display("FAIL to_rx_push: rx_valid=%b required 0", rx_valid); end
    tick(100);
    checks += 3;
    if (n_starts != 1)        begin errors++; $display("FAIL to_relaunch: got %0d starts required 1", n_starts); end
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", err_timeout); end
    if (rx_valid !== 1'b0)    begin errors++; $display("FAIL to_rx_late: rx_valid=%b required 0", rx_valid); end
    for (int i = 0; i < 3; i++) write_byte(8'h30 + 8'(i), 1'b1);
    checks += 2;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL to_tx_fill: tx_ready=%b required 0", tx_ready); end
    if (n_starts != 1)     begin errors++; $display("FAIL to_blocked: got %0d starts required 1", n_starts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_random();
    test_backpressure();
    test_tx_full();
    test_reset_midtransfer();
    test_timeout();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
